usart_tx_fifo: RTL

Parametrised USART transmitter with a built-in transmit FIFO, configurable frame format (5–9 data bits, optional parity, 1–2 stop bits) and a valid/ready write interface. It is the next-generation transmit path of the USART: it replaces the single-word, toggle-handshake transmitter and lets upstream logic queue several words that leave the line back to back. The block sits between the system-side producer and the `tx` pad.

---
 rtl/usart_tx_fifo.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/usart_tx_fifo.sv
// usart_tx_fifo: USART transmitter with a built-in transmit FIFO.
//
// Upstream logic queues words over a valid/ready interface; the serializer
// pops them and sends start bit, DATA_BITS data bits (LSB first), an
// optional parity bit and STOP_BITS stop bits, back to back while words
// remain queued.
//
// Optional feature macro: USART_TX_BREAK_EN
//   When defined, adds the brk input. brk holds the line low (BREAK) once
//   the current frame has finished. After release, one stop-bit time of
//   idle high is sent before normal operation resumes.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   brk        in   break request (only with USART_TX_BREAK_EN)
//   tx_data    in   [DATA_BITS-1:0] word to queue
//   tx_valid   in   tx_data is valid
//   tx_ready   out  FIFO can accept a word (not full)
//   tx         out  serial line, idle high
//   busy       out  serializer not idle
//   done       out  one-cycle pulse in the final clock of each frame
//   fifo_count out  [$clog2(FIFO_DEPTH+1)-1:0] occupied FIFO entries
module usart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 8
) (
`ifdef USART_TX_BREAK_EN
  input  logic                                 brk,
`endif
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [DATA_BITS-1:0]                 tx_data,
  input  logic                                 tx_valid,
  output logic                                 tx_ready,
  output logic                                 tx,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FCNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [0:0]        STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
`ifdef USART_TX_BREAK_EN
    ,
    S_BRK,
    S_BRK_END
`endif
  } state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~^w : ^w;
  endfunction

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [0:0]           stop_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 push, pop, empty, bit_end, counting;

  // FIFO control; tx_ready comes from the registered count, so a pop in the
  // same cycle never opens a slot for a push while full.
  assign tx_ready = (fifo_count != FULL_CNT);
  assign empty    = (fifo_count == '0);
  assign push     = tx_valid && tx_ready;
  // A word is popped on every transition into START.
  assign pop      = (state_nxt == S_START) && (state != S_START);
  assign bit_end  = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Baud counter runs in every timed state and restarts at each bit boundary.
  always_comb begin
    counting = (state != S_IDLE);
`ifdef USART_TX_BREAK_EN
    if (state == S_BRK) counting = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      if (!counting || bit_end) baud_cnt <= '0;
      else                      baud_cnt <= baud_cnt + 1'b1;
      if (state != S_DATA) bit_cnt <= '0;
      else if (bit_end)    bit_cnt <= bit_cnt + 1'b1;
      if (state != S_STOP) stop_cnt <= '0;
      else if (bit_end)    stop_cnt <= stop_cnt + 1'b1;
    end
  end

  // Shift register and parity bit are loaded together at the pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_reg <= mem[rd_ptr];
      par_bit   <= parity_of(mem[rd_ptr]);
    end else if (state == S_DATA && bit_end) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
`ifdef USART_TX_BREAK_EN
        if (brk) state_nxt = S_BRK;
        else
`endif
        if (!empty) state_nxt = S_START;
      end
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && bit_cnt == BIT_LAST)
                 state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        if (bit_end && stop_cnt == STOP_LAST) begin
`ifdef USART_TX_BREAK_EN
          if (brk) state_nxt = S_BRK;
          else
`endif
          if (!empty) state_nxt = S_START;
          else        state_nxt = S_IDLE;
        end
      end
`ifdef USART_TX_BREAK_EN
      S_BRK: if (!brk) state_nxt = S_BRK_END;
      S_BRK_END: begin
        if (bit_end) begin
          if (brk)         state_nxt = S_BRK;
          else if (!empty) state_nxt = S_START;
          else             state_nxt = S_IDLE;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state != S_IDLE);
    done = (state == S_STOP) && bit_end && (stop_cnt == STOP_LAST);
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_reg[0];
      S_PAR:   tx = par_bit;
`ifdef USART_TX_BREAK_EN
      S_BRK:   tx = 1'b0;
`endif
      default: tx = 1'b1;
    endcase
  end

endmodule
